regbank_wr_arb: RTL
===================

Name: regbank_wr_arb

Overview:
- Round-robin write arbiter that shares a bank of NREG 8-bit load-enable registers among NREQ requesters.
- Each requester presents a target register index and data.
- The block grants one requester per cycle and drives that register's one-hot select and the shared data bus.
- The register bank captures on the negedge of clk in the middle of the grant cycle; this controller runs on the posedge.

Parameters:
- NREQ, 4, number of requesters (2..8)
- NREG, 4, number of registers in the bank (1..16)
- DW, 8, data width
- AW, 4, register index width; must satisfy 2**AW >= NREG

Ports:
- clk  input  1  system clock; this block uses the posedge only
- rst  input  1  asynchronous, active-high reset
- req  input  NREQ  per-requester write request; held until the matching gnt is seen
- req_addr  input  NREQ*AW  packed register indices; requester i occupies bits [i*AW +: AW]
- req_data  input  NREQ*DW  packed write data; requester i occupies bits [i*DW +: DW]
- gnt  output  NREQ  one-hot grant, high for exactly one cycle
- reg_sel  output  NREG  one-hot load enable to the register bank
- reg_din  output  DW  shared write data to the register bank
- addr_err  output  1  one-cycle pulse when the granted index is >= NREG
- busy  output  1  high while in ISSUE

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high. Ports are named clk and rst.
- While rst is high: state=IDLE, rr_ptr=0, and gnt, reg_sel, reg_din, addr_err, busy are all 0.
- All outputs are registered on posedge clk. No combinational path from req to any output.
- States: IDLE, ISSUE.
- Arbitration at each posedge:
  - eligible = req; in ISSUE, the last-granted requester's bit is masked off.
  - Search starts at rr_ptr, wraps modulo NREQ, and picks the first eligible requester w.
- If eligible is nonzero:
  - next state ISSUE; gnt = 1<<w.
  - reg_sel = 1<<req_addr[w] if req_addr[w] < NREG, else 0 with addr_err=1.
  - reg_din = req_data[w]; busy=1.
  - rr_ptr = (w+1) mod NREQ; last = w.
- If eligible is zero: next state IDLE; gnt, reg_sel, addr_err and busy return to 0; reg_din holds its last value.
- Latency: a req asserted before posedge k produces gnt, reg_sel and reg_din during cycle k..k+1. The register captures at the negedge inside that cycle.
- Requester contract:
  - Samples gnt at posedge k+1 and drops req or presents new data after that edge.
  - req_addr and req_data must stay stable while req is high and gnt is not yet seen.
- Throughput:
  - Distinct requesters can be granted on consecutive cycles (ISSUE to ISSUE).
  - The same requester is granted at most every other cycle, because of the last-granted mask. This prevents a double write from a stale req.
- Fairness: with all NREQ requesting continuously, grants cycle 0,1,...,NREQ-1,0,... Each requester waits at most NREQ-1 grant cycles.
- Two requesters targeting the same register in consecutive cycles: both writes occur in grant order; the later write wins.
- Reset asserted during ISSUE: reg_sel clears asynchronously. If rst rises before the negedge, the bank sees no load. After reset, arbitration restarts from requester 0.
- reg_sel and gnt are never more than one-hot; reg_sel=0 whenever gnt=0.

Optional Feature:
- Macro: REGBANK_WR_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins. rr_ptr is removed, and the search always starts at 0. The last-granted mask in ISSUE is kept.
- Undefined: round-robin as above.

Test Plan:
- Reset values: drive rst=1 asynchronously mid-cycle -> gnt, reg_sel, busy and addr_err are all 0 immediately; after release, the first grant goes to the lowest requesting index.
- Single write: req=4'b0100, addr[2]=3, data[2]=8'hA5 at edge k -> cycle k: gnt=4'b0100, reg_sel=4'b1000, reg_din=8'hA5; register 3 reads 8'hA5 after the negedge.
- Full contention: req=4'b1111 held (requesters re-raise req after each gnt) -> gnt sequence 0001,0010,0100,1000,0001 on consecutive cycles with busy=1 throughout. With FIXED_PRIO_EN defined -> 0001 alternates with 0010.
- Same requester back-to-back: req0 held high across the grant edge -> gnt=0001, then 0000 (IDLE), then 0001; never two consecutive grants to requester 0.
- Bad index, with NREG=4 and AW=4: req1 with addr=4'd9 -> gnt=0010, reg_sel=0, addr_err=1 for one cycle; no register changes.
- Reset mid-write: assert rst during the ISSUE cycle before the negedge -> reg_sel=0 at the negedge, target register keeps its old value, state returns to IDLE.

Source files
------------

// File: rtl/regbank_wr_arb_if.sv
// Request/grant and register-bank write bus shared by regbank_wr_arb and its requesters.
// The arbiter connects through the slave modport and requesters through the master modport.
interface regbank_wr_arb_if #(
   parameter int NREQ = 4,
   parameter int NREG = 4,
   parameter int DW   = 8,
   parameter int AW   = 4
);
   logic [NREQ-1:0]    req;
   logic [NREQ*AW-1:0] req_addr;
   logic [NREQ*DW-1:0] req_data;
   logic [NREQ-1:0]    gnt;
   logic [NREG-1:0]    reg_sel;
   logic [DW-1:0]      reg_din;
   logic               addr_err;
   logic               busy;

   modport master (
      output req, req_addr, req_data,
      input  gnt, reg_sel, reg_din, addr_err, busy
   );

   modport slave (
      input  req, req_addr, req_data,
      output gnt, reg_sel, reg_din, addr_err, busy
   );
endinterface

// File: rtl/regbank_wr_arb.sv
// Round-robin write arbiter in front of an NREG-entry load-enable register bank.
// Define REGBANK_WR_ARB_FIXED_PRIO_EN to get fixed priority, where the lowest index wins.
module regbank_wr_arb #(
   parameter int NREQ = 4,
   parameter int NREG = 4,
   parameter int DW   = 8,
   parameter int AW   = 4
) (
   input  logic             clk,
   input  logic             rst,
   regbank_wr_arb_if.slave  bus
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef logic [PW-1:0] idx_t;
   typedef enum logic [0:0] {S_IDLE = 1'b0, S_ISSUE = 1'b1} state_t;

   state_t          state_q, state_d;
   idx_t            last_q, last_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [NREG-1:0] reg_sel_q, reg_sel_d;
   logic [DW-1:0]   reg_din_q, reg_din_d;
   logic            addr_err_q, addr_err_d;
   logic            busy_q, busy_d;

   logic [NREQ-1:0] eligible_s;
   logic            found_s;
   idx_t            win_s;
   idx_t            start_s;
   logic [AW-1:0]   win_addr_s;
   logic            addr_ok_s;

   // Scan from start and return {found, index} of the first set bit, wrapping modulo NREQ.
   function automatic logic [PW:0] pick(input logic [NREQ-1:0] elig, input idx_t start);
      logic found;
      idx_t win;
      int   pos;
      found = 1'b0;
      win   = '0;
      for (int k = 0; k < NREQ; k++) begin
         pos = (int'(start) + k) % NREQ;
         if (!found && elig[pos]) begin
            found = 1'b1;
            win   = idx_t'(pos);
         end else begin
            found = found;
         end
      end
      return {found, win};
   endfunction

`ifdef REGBANK_WR_ARB_FIXED_PRIO_EN
   assign start_s = '0;
`else
   idx_t rr_ptr_q, rr_ptr_d;

   assign start_s = rr_ptr_q;

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (found_s) begin
         rr_ptr_d = (int'(win_s) == NREQ - 1) ? '0 : idx_t'(win_s + idx_t'(1));
      end else begin
         rr_ptr_d = rr_ptr_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_q <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
      end
   end
`endif

   // Masking the last winner while in ISSUE stops a stale req from writing twice.
   always_comb begin
      eligible_s = bus.req;
      if (state_q == S_ISSUE) begin
         eligible_s[last_q] = 1'b0;
      end else begin
         eligible_s = bus.req;
      end
      {found_s, win_s} = pick(eligible_s, start_s);
      win_addr_s = bus.req_addr[win_s*AW +: AW];
      addr_ok_s  = (int'(win_addr_s) < NREG);
   end

   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      gnt_d      = '0;
      reg_sel_d  = '0;
      reg_din_d  = reg_din_q;
      addr_err_d = 1'b0;
      busy_d     = 1'b0;
      case (state_q)
         S_IDLE, S_ISSUE: begin
            if (found_s) begin
               state_d    = S_ISSUE;
               last_d     = win_s;
               gnt_d      = NREQ'(1'b1) << win_s;
               reg_din_d  = bus.req_data[win_s*DW +: DW];
               busy_d     = 1'b1;
               if (addr_ok_s) begin
                  reg_sel_d  = NREG'(1'b1) << win_addr_s;
                  addr_err_d = 1'b0;
               end else begin
                  reg_sel_d  = '0;
                  addr_err_d = 1'b1;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         last_q     <= '0;
         gnt_q      <= '0;
         reg_sel_q  <= '0;
         reg_din_q  <= '0;
         addr_err_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         gnt_q      <= gnt_d;
         reg_sel_q  <= reg_sel_d;
         reg_din_q  <= reg_din_d;
         addr_err_q <= addr_err_d;
         busy_q     <= busy_d;
      end
   end

   assign bus.gnt      = gnt_q;
   assign bus.reg_sel  = reg_sel_q;
   assign bus.reg_din  = reg_din_q;
   assign bus.addr_err = addr_err_q;
   assign bus.busy     = busy_q;

endmodule
